wb_trace_tx: RTL and testbench
==============================

# wb_trace_tx

Synthesizable retirement-trace transmitter for the diad core. It taps the writeback stage and captures each retired instruction's PC, instruction word, GP target, result and flags into a small record FIFO. It serializes each record as a 12-byte framed packet on a valid/ready byte stream, so off-chip logic or a UART bridge can reconstruct the pipeline trace.

## Interface
- `DEPTH`, 4: record FIFO entries; power of two, at least 2.
- `iw_clk` in 1: core clock.
- `iw_rst_n` in 1: asynchronous, active-low reset.
- `iw_en` in 1: trace enable. While low, WB events are ignored and `seq` does not advance.
- `iw_wb_valid` in 1: one instruction retires this cycle.
- `iw_wb_pc` in 24: PC of the retiring instruction.
- `iw_wb_instr` in 24: instruction word.
- `iw_wb_we` in 1: GP write performed.
- `iw_wb_tgt_gp` in 4: GP target index.
- `iw_wb_result` in 24: writeback result.
- `iw_wb_flags` in 4: {Z,N,C,V} after the instruction.
- `ow_tx_valid` out 1: `ow_tx_data` holds a byte.
- `ow_tx_data` out 8: stream byte.
- `iw_tx_ready` in 1: sink accepts the byte.
- `ow_drop_cnt` out 8: saturating count of dropped events.
- `ow_busy` out 1: FIFO is non-empty or a packet is in flight.

## Operation
- **Event:** an event is `iw_en && iw_wb_valid` at a rising edge. Each event advances the 6-bit `seq`, which wraps from 63 to 0, whether the event is stored or dropped.
- **Storing:** if the FIFO is not full, the record {pc, instr, result, flags, tgt_gp, we, seq, lost} is written. `seq` in the record is the pre-increment value. After a successful write, `lost` clears.
- **Dropping:** if the FIFO is full, the record is dropped, `ow_drop_cnt` increments (saturating at 255) and the sticky `lost` bit is set. Fullness is the registered state before any same-edge pop, so a pop on the same edge does not rescue the event.
- **Packet format** (12 bytes, multi-byte fields MSB first):
  - byte 0: sync 0xD1
  - byte 1: {flags[3:0], tgt_gp[3:0]}
  - byte 2: {lost, we, seq[5:0]}
  - bytes 3–5: pc
  - bytes 6–8: instr
  - bytes 9–11: result
- **Serializer FSM:**
  - IDLE: if the FIFO is non-empty, pop into the packet register, set `idx=0`, go to SEND.
  - SEND: `ow_tx_valid=1`, `ow_tx_data=byte[idx]`. On `iw_tx_ready`, `idx++`.
  - On the handshake at `idx==11`: if the FIFO is non-empty, pop and restart at `idx=0` in SEND with no bubble; otherwise go to IDLE.
- **Stream rules:** `ow_tx_data` is held stable while valid is high and ready is low, and valid never drops mid-packet. Deasserting `iw_en` mid-packet does not truncate the packet; queued records still drain.
- **Reset** (asynchronous, any time, including mid-packet):
  - `ow_tx_valid=0`, `ow_tx_data=0`, `ow_drop_cnt=0`, `ow_busy=0`
  - `seq=0`, `lost=0`, FIFO empty, FSM in IDLE
  - A partially sent packet is abandoned.

## Timing
- **Latency:** event sampled at edge E0 → record in FIFO after E0 → popped at E1 (if IDLE) → `ow_tx_valid` with byte 0 during the cycle after E1.
- **Throughput:** one byte per cycle under continuous ready, i.e. 12 cycles per record. Sustained retirement faster than 1/12 per cycle fills the FIFO and then drops.
- `ow_busy` is registered and reflects FIFO and FSM state after each edge.
- A FIFO push and pop on the same edge are both performed when the FIFO is neither empty nor full.

## Structure
- **Package `trace_pkg`** holds:
  - sync byte `0xD1`
  - packet length 12
  - record field widths and offsets
  - FSM state encodings
- **Sub-module `trace_fifo`:** synchronous FIFO with `DEPTH` × 88-bit entries, ports push/pop/full/empty, same async active-low reset. It has no internal bypass.
- **Top level** holds the event capture, `seq`/`lost`/drop logic, the serializer FSM and the byte mux.

## Test plan
- **Single event:** reset, `iw_en=1`, one event with pc=0x000010, instr=0x123456, we=1, tgt=3, result=0x00ABCD, flags=0b0100, ready held high → 12 bytes D1 43 40 00 00 10 12 34 56 00 AB CD. Byte 0 appears 2 edges after the event; `ow_busy` is low after the last byte.
- **Backpressure:** during a packet, ready toggles 1,0,0,1 → `ow_tx_data` is stable during the stalls, no byte is duplicated or skipped, and the next packet's D1 follows the previous byte 11 with no gap.
- **Overflow:** hold ready low and issue 7 consecutive events with `DEPTH=4` → 4 stored (one already popped into the serializer, so effectively 5 held) and `ow_drop_cnt` counts the rest. The first record stored after the drops has `lost=1`, and its `seq` shows the gap.
- **Seq wrap and enable:** 70 events with 5 of them while `iw_en=0` → the disabled ones leave no packet and no seq advance; `seq` wraps 63→0.
- **Drop saturation:** 300 events with ready low → `ow_drop_cnt` stays at 255.
- **Reset mid-packet:** assert `iw_rst_n` low after byte 5 → outputs go immediately to reset values. After release, a new event produces a packet with `seq=0` that starts with D1.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg
// Shared definitions for the writeback trace transmitter:
//   - packet framing constants (sync byte, packet length)
//   - trace record field widths and bit offsets within the 88-bit record
//   - packed record struct matching those offsets
//   - serializer FSM state encoding
//   - pkt_byte(): maps a record and byte index to the outgoing stream byte
package trace_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hD1;
  localparam int         PKT_LEN   = 12;

  // Record field widths
  localparam int PC_W     = 24;
  localparam int INSTR_W  = 24;
  localparam int RESULT_W = 24;
  localparam int FLAGS_W  = 4;
  localparam int GP_W     = 4;
  localparam int SEQ_W    = 6;

  // Record field offsets, LSB first
  localparam int LOST_OFF   = 0;
  localparam int SEQ_OFF    = LOST_OFF + 1;
  localparam int WE_OFF     = SEQ_OFF + SEQ_W;
  localparam int TGT_OFF    = WE_OFF + 1;
  localparam int FLAGS_OFF  = TGT_OFF + GP_W;
  localparam int RESULT_OFF = FLAGS_OFF + FLAGS_W;
  localparam int INSTR_OFF  = RESULT_OFF + RESULT_W;
  localparam int PC_OFF     = INSTR_OFF + INSTR_W;
  localparam int REC_W      = PC_OFF + PC_W;

  // Field order mirrors the offsets above, MSB (pc) first
  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [INSTR_W-1:0]  instr;
    logic [RESULT_W-1:0] result;
    logic [FLAGS_W-1:0]  flags;
    logic [GP_W-1:0]     tgt_gp;
    logic                we;
    logic [SEQ_W-1:0]    seq;
    logic                lost;
  } trace_rec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  // Multi-byte fields go out MSB first
  function automatic logic [7:0] pkt_byte(input trace_rec_t rec, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = SYNC_BYTE;
      4'd1:    b = {rec.flags, rec.tgt_gp};
      4'd2:    b = {rec.lost, rec.we, rec.seq};
      4'd3:    b = rec.pc[23:16];
      4'd4:    b = rec.pc[15:8];
      4'd5:    b = rec.pc[7:0];
      4'd6:    b = rec.instr[23:16];
      4'd7:    b = rec.instr[15:8];
      4'd8:    b = rec.instr[7:0];
      4'd9:    b = rec.result[23:16];
      4'd10:   b = rec.result[15:8];
      4'd11:   b = rec.result[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
// Synchronous record FIFO, DEPTH x WIDTH, no write-to-read bypass.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push         write wr_data (ignored while full)
//   pop          advance read pointer (ignored while empty)
//   wr_data      record to store
//   rd_data      record at the head, valid while !empty
//   full, empty  registered occupancy flags
//   level        current number of stored records
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 88
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset; the empty flag guards every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_trace_tx.sv
// wb_trace_tx
// Retirement-trace transmitter. Captures each retired instruction from the
// writeback stage into a record FIFO and serializes records as 12-byte
// framed packets on a valid/ready byte stream.
// Ports:
//   iw_clk, iw_rst_n        core clock, asynchronous active-low reset
//   iw_en                   trace enable; events ignored while low
//   iw_wb_valid             an instruction retires this cycle
//   iw_wb_pc/instr/result   24-bit PC, instruction word, writeback result
//   iw_wb_we, iw_wb_tgt_gp  GP write flag and target index
//   iw_wb_flags             {Z,N,C,V} after the instruction
//   ow_tx_valid/ow_tx_data  outgoing byte stream
//   iw_tx_ready             sink accepts the current byte
//   ow_drop_cnt             saturating count of events lost to a full FIFO
//   ow_busy                 FIFO non-empty or packet in flight (registered)
// DEPTH must be a power of two and at least 2.
module wb_trace_tx
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        iw_clk,
  input  logic        iw_rst_n,
  input  logic        iw_en,
  input  logic        iw_wb_valid,
  input  logic [23:0] iw_wb_pc,
  input  logic [23:0] iw_wb_instr,
  input  logic        iw_wb_we,
  input  logic [3:0]  iw_wb_tgt_gp,
  input  logic [23:0] iw_wb_result,
  input  logic [3:0]  iw_wb_flags,
  output logic        ow_tx_valid,
  output logic [7:0]  ow_tx_data,
  input  logic        iw_tx_ready,
  output logic [7:0]  ow_drop_cnt,
  output logic        ow_busy
);

  localparam int         LW      = $clog2(DEPTH) + 1;
  localparam logic [3:0] LAST_IX = 4'(PKT_LEN - 1);

  logic             wb_event;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LW-1:0]    fifo_level;
  logic [LW-1:0]    level_next;
  logic [REC_W-1:0] wr_rec;
  logic [REC_W-1:0] rd_rec;

  logic [SEQ_W-1:0] seq;
  logic             lost;
  logic [7:0]       drop_cnt;

  tx_state_t        state;
  tx_state_t        state_next;
  logic [3:0]       idx;
  logic [3:0]       idx_next;
  logic             load_pkt;
  trace_rec_t       pkt;
  logic             busy;
  logic             busy_next;

  assign wb_event  = iw_en && iw_wb_valid;
  // Fullness is the registered flag, so a same-edge pop cannot rescue an event
  assign fifo_push = wb_event && !fifo_full;

  // Record carries the pre-increment seq and the lost flag from before this event
  always_comb begin
    wr_rec = '0;
    wr_rec[PC_OFF     +: PC_W]     = iw_wb_pc;
    wr_rec[INSTR_OFF  +: INSTR_W]  = iw_wb_instr;
    wr_rec[RESULT_OFF +: RESULT_W] = iw_wb_result;
    wr_rec[FLAGS_OFF  +: FLAGS_W]  = iw_wb_flags;
    wr_rec[TGT_OFF    +: GP_W]     = iw_wb_tgt_gp;
    wr_rec[WE_OFF]                 = iw_wb_we;
    wr_rec[SEQ_OFF    +: SEQ_W]    = seq;
    wr_rec[LOST_OFF]               = lost;
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (iw_clk),
    .rst_n   (iw_rst_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (wr_rec),
    .rd_data (rd_rec),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // seq advances on every event, stored or dropped; lost stays set until a store
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      seq      <= '0;
      lost     <= 1'b0;
      drop_cnt <= '0;
    end else if (wb_event) begin
      seq <= seq + 1'b1;
      if (fifo_full) begin
        lost <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end else begin
        lost <= 1'b0;
      end
    end
  end

  // On the final byte handshake a waiting record is loaded straight into
  // the packet register so back-to-back packets have no bubble
  always_comb begin
    state_next = state;
    idx_next   = idx;
    fifo_pop   = 1'b0;
    load_pkt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          load_pkt   = 1'b1;
          idx_next   = 4'd0;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (iw_tx_ready) begin
          if (idx == LAST_IX) begin
            idx_next = 4'd0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              load_pkt = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            idx_next = idx + 4'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = 4'd0;
      end
    endcase
  end

  // Busy is registered, so it is derived from the post-edge occupancy
  always_comb begin
    level_next = fifo_level + LW'(fifo_push) - LW'(fifo_pop);
    busy_next  = (state_next == ST_SEND) || (level_next != '0);
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state <= ST_IDLE;
      idx   <= 4'd0;
      pkt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      busy  <= busy_next;
      if (load_pkt) begin
        pkt <= trace_rec_t'(rd_rec);
      end
    end
  end

  // Byte mux driven from registered state only, so data holds during stalls
  always_comb begin
    ow_tx_valid = 1'b0;
    ow_tx_data  = 8'h00;
    if (state == ST_SEND) begin
      ow_tx_valid = 1'b1;
      ow_tx_data  = pkt_byte(pkt, idx);
    end
  end

  assign ow_drop_cnt = drop_cnt;
  assign ow_busy     = busy;

endmodule

// File: tb/tb_wb_trace_tx.sv
// tb_wb_trace_tx
// Scoreboard bench for wb_trace_tx: stimulus pushes expected packet bytes
// into a queue; a negedge monitor pops and compares every accepted byte and
// checks that data holds during stalls.
module tb_wb_trace_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        wb_valid = 1'b0;
  logic [23:0] wb_pc = '0;
  logic [23:0] wb_instr = '0;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_tgt = '0;
  logic [23:0] wb_result = '0;
  logic [3:0]  wb_flags = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic [7:0]  drop_cnt;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];

  logic [5:0]  m_seq = '0;
  logic        m_lost = 1'b0;
  int          m_drops = 0;

  logic        stall_pending = 1'b0;
  logic [7:0]  stall_data = '0;

  always #5 clk = ~clk;

  wb_trace_tx #(.DEPTH(4)) dut (
    .iw_clk       (clk),
    .iw_rst_n     (rst_n),
    .iw_en        (en),
    .iw_wb_valid  (wb_valid),
    .iw_wb_pc     (wb_pc),
    .iw_wb_instr  (wb_instr),
    .iw_wb_we     (wb_we),
    .iw_wb_tgt_gp (wb_tgt),
    .iw_wb_result (wb_result),
    .iw_wb_flags  (wb_flags),
    .ow_tx_valid  (tx_valid),
    .ow_tx_data   (tx_data),
    .iw_tx_ready  (tx_ready),
    .ow_drop_cnt  (drop_cnt),
    .ow_busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic expect_packet(input logic [23:0] pc, input logic [23:0] instr, input logic [23:0] result,
                               input logic [3:0] flags, input logic [3:0] tgt, input logic lost,
                               input logic we, input logic [5:0] seq);
    exp_q.push_back(8'hD1);
    exp_q.push_back({flags, tgt});
    exp_q.push_back({lost, we, seq});
    exp_q.push_back(pc[23:16]);
    exp_q.push_back(pc[15:8]);
    exp_q.push_back(pc[7:0]);
    exp_q.push_back(instr[23:16]);
    exp_q.push_back(instr[15:8]);
    exp_q.push_back(instr[7:0]);
    exp_q.push_back(result[23:16]);
    exp_q.push_back(result[15:8]);
    exp_q.push_back(result[7:0]);
  endtask

  // One cycle of WB activity; stored says whether the FIFO has room (hand-derived)
  task automatic applyStimulus(input logic [23:0] pc, input logic [23:0] instr, input logic [23:0] result,
                               input logic we, input logic [3:0] tgt, input logic [3:0] flags,
                               input logic enable, input logic stored);
    en        = enable;
    wb_valid  = 1'b1;
    wb_pc     = pc;
    wb_instr  = instr;
    wb_result = result;
    wb_we     = we;
    wb_tgt    = tgt;
    wb_flags  = flags;
    if (enable) begin
      if (stored) begin
        expect_packet(pc, instr, result, flags, tgt, m_lost, we, m_seq);
        m_lost = 1'b0;
      end else begin
        m_lost = 1'b1;
        if (m_drops < 255) m_drops++;
      end
      m_seq = m_seq + 6'd1;
    end
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    en       = 1'b1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wb_valid = 1'b0;
    exp_q.delete();
    m_seq   = '0;
    m_lost  = 1'b0;
    m_drops = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 32'(n >= 2000), 32'd0);
  endtask

  // Monitor: compares accepted bytes and checks stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        checkOutput("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, stall_data});
      end
      stall_pending = 1'b0;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte at %0t", tx_data, $time);
        end else begin
          checkOutput("stream_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
      end else if (tx_valid) begin
        stall_pending = 1'b1;
        stall_data    = tx_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic rdy_pat [4];
    int   run;
    int   cnt;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_data", 32'(tx_data), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    do_reset();

    // Single event with hand-computed packet and latency
    $display("[TB] single event");
    tx_ready = 1'b1;
    en       = 1'b1;
    exp_q.push_back(8'hD1); exp_q.push_back(8'h43); exp_q.push_back(8'h40);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h10);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
    exp_q.push_back(8'h00); exp_q.push_back(8'hAB); exp_q.push_back(8'hCD);
    wb_valid = 1'b1; wb_pc = 24'h000010; wb_instr = 24'h123456; wb_we = 1'b1;
    wb_tgt = 4'd3; wb_result = 24'h00ABCD; wb_flags = 4'b0100;
    m_seq = 6'd1;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    checkOutput("lat_e0_valid", 32'(tx_valid), 32'd0);
    checkOutput("lat_e0_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    checkOutput("lat_e1_byte0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hD1});
    repeat (11) @(posedge clk);
    #1;
    checkOutput("busy_last_byte", 32'(busy), 32'd1);
    @(posedge clk); #1;
    checkOutput("busy_after_pkt", {30'd0, busy, tx_valid}, 32'd0);
    wait_drain("drain_single");

    // Back-to-back packets must stream without a gap
    $display("[TB] gapless back-to-back");
    applyStimulus(24'hA00001, 24'hBEEF01, 24'h111111, 1'b0, 4'd7, 4'b1001, 1'b1, 1'b1);
    applyStimulus(24'hA00002, 24'hBEEF02, 24'h222222, 1'b1, 4'd9, 4'b0011, 1'b1, 1'b1);
    run = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx_valid) run++;
      else break;
    end
    checkOutput("gapless_run", 32'(run), 32'd24);
    wait_drain("drain_gapless");

    // Backpressure pattern 1,0,0,1 across two packets
    $display("[TB] backpressure");
    applyStimulus(24'h0C0C0C, 24'h5A5A5A, 24'hFEDCBA, 1'b1, 4'd15, 4'b1111, 1'b1, 1'b1);
    applyStimulus(24'h0D0D0D, 24'hA5A5A5, 24'h012345, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 48; k++) begin
      tx_ready = rdy_pat[k % 4];
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    wait_drain("drain_bp");

    // Overflow: 5 held (1 in serializer + 4 in FIFO), 2 dropped
    $display("[TB] overflow");
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(24'h200000 + 24'(i), 24'h300000 + 24'(i), 24'h400000 + 24'(i),
                    1'b1, 4'(i), 4'(i + 1), 1'b1, i < 5);
    end
    checkOutput("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    checkOutput("ovf_busy", 32'(busy), 32'd1);
    tx_ready = 1'b1;
    wait_drain("drain_ovf");
    applyStimulus(24'h2000FF, 24'h3000FF, 24'h4000FF, 1'b1, 4'd5, 4'd6, 1'b1, 1'b1);
    wait_drain("drain_ovf_lost");
    checkOutput("ovf_drop_hold", 32'(drop_cnt), 32'(m_drops));

    // Seq wrap with disabled cycles interleaved
    $display("[TB] seq wrap and enable");
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 70; i++) begin
      applyStimulus(24'h500000 + 24'(i), 24'(i * 7 + 5), 24'hABC000 + 24'(i),
                    1'(i % 2), 4'(i), 4'(i >> 2), (i % 14) != 7, 1'b1);
      repeat (12) @(posedge clk);
      #1;
    end
    wait_drain("drain_wrap");
    checkOutput("wrap_drop_cnt", 32'(drop_cnt), 32'd0);

    // Drop saturation
    $display("[TB] drop saturation");
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(24'h600000 + 24'(i), 24'h700000 + 24'(i), 24'h800000 + 24'(i),
                    1'b0, 4'd2, 4'd8, 1'b1, i < 5);
    end
    checkOutput("sat_drop_cnt", 32'(drop_cnt), 32'd255);
    tx_ready = 1'b1;
    wait_drain("drain_sat");
    checkOutput("sat_drop_hold", 32'(drop_cnt), 32'd255);

    // Reset in the middle of a packet
    $display("[TB] reset mid-packet");
    do_reset();
    tx_ready = 1'b1;
    applyStimulus(24'h900001, 24'h900002, 24'h900003, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1);
    applyStimulus(24'h900011, 24'h900012, 24'h900013, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1);
    cnt = 0;
    for (int k = 0; k < 40 && cnt < 6; k++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) cnt++;
    end
    checkOutput("midrst_bytes_seen", 32'(cnt), 32'd6);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_seq   = '0;
    m_lost  = 1'b0;
    m_drops = 0;
    #1;
    checkOutput("midrst_valid", 32'(tx_valid), 32'd0);
    checkOutput("midrst_data", 32'(tx_data), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(24'hCAFE01, 24'hCAFE02, 24'hCAFE03, 1'b0, 4'd4, 4'd1, 1'b1, 1'b1);
    wait_drain("drain_midrst");

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
